// File: rtl/lwr_prf_pkg.sv
// Shared constants and types for the LWR PRF key path.
// Used by the key ROM, the run-time key loader and the PRF core.
package lwr_prf_pkg;

  localparam int N_LWR_DFLT  = 445;
  localparam int BYTE_W_DFLT = 8;

  function automatic int key_bytes(input int n_bits, input int beat_w);
    return (n_bits + beat_w - 1) / beat_w;
  endfunction

  localparam int KEY_BYTES_DFLT = key_bytes(N_LWR_DFLT, BYTE_W_DFLT);
  localparam int KEY_ADDR_W     = $clog2(N_LWR_DFLT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } loader_state_e;

endpackage

// File: rtl/secret_key_loader.sv
// Run-time provisioned LWR secret key: byte-stream loader, zeroize, and the
// same single-bit read port as the fixed key ROM so it can replace it directly.
module secret_key_loader
  import lwr_prf_pkg::*;
#(
  parameter int N_LWR  = N_LWR_DFLT,
  parameter int BYTE_W = BYTE_W_DFLT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     zeroize,
  input  logic                     start,
  input  logic [BYTE_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     busy,
  output logic                     key_valid,
  input  logic [$clog2(N_LWR)-1:0] addr,
  output logic                     key_bit
);

  localparam int KEY_BYTES = key_bytes(N_LWR, BYTE_W);
  localparam int CNT_W     = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int PAD_W     = KEY_BYTES * BYTE_W;
  localparam int PAD_IDX_W = $clog2(PAD_W);
  localparam int ADDR_W    = $clog2(N_LWR);

  loader_state_e          state_r;
  loader_state_e          state_nxt_s;
  logic [CNT_W-1:0]       byte_cnt_r;
  logic [CNT_W-1:0]       byte_cnt_nxt_s;
  logic [N_LWR-1:0]       key_r;
  logic [N_LWR-1:0]       key_nxt_s;
  logic [PAD_W-1:0]       key_pad_s;
  logic [PAD_IDX_W-1:0]   wr_base_s;
  logic                   xfer_s;

  // State, counter and key register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      byte_cnt_r <= '0;
      key_r      <= '0;
    end else begin
      state_r    <= state_nxt_s;
      byte_cnt_r <= byte_cnt_nxt_s;
      key_r      <= key_nxt_s;
    end
  end

  // Next-state logic: zeroize beats start, start beats a beat transfer.
  always_comb begin
    state_nxt_s    = state_r;
    byte_cnt_nxt_s = byte_cnt_r;
    key_nxt_s      = key_r;
    xfer_s         = in_valid && (state_r == LOAD);
    // Beat written into a byte-aligned shadow so the tail bits of the final
    // beat fall off the top instead of needing a per-bit range check.
    wr_base_s      = PAD_IDX_W'(byte_cnt_r) * PAD_IDX_W'(BYTE_W);
    key_pad_s      = '0;
    key_pad_s[N_LWR-1:0] = key_r;
    key_pad_s[wr_base_s +: BYTE_W] = in_data;
    if (zeroize) begin
      state_nxt_s    = IDLE;
      byte_cnt_nxt_s = '0;
      key_nxt_s      = '0;
    end else if (start) begin
      state_nxt_s    = LOAD;
      byte_cnt_nxt_s = '0;
      key_nxt_s      = '0;
    end else if (xfer_s) begin
      key_nxt_s = key_pad_s[N_LWR-1:0];
      if (byte_cnt_r == CNT_W'(KEY_BYTES - 1)) begin
        state_nxt_s    = READY;
        byte_cnt_nxt_s = '0;
      end else begin
        byte_cnt_nxt_s = byte_cnt_r + CNT_W'(1);
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Status decode and the gated read port.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    key_valid = 1'b0;
    key_bit   = 1'b0;
    case (state_r)
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      READY: begin
        key_valid = 1'b1;
      end
      IDLE: begin
        key_valid = 1'b0;
      end
      default: begin
        key_valid = 1'b0;
      end
    endcase
    if (key_valid && ({1'b0, addr} < (ADDR_W + 1)'(N_LWR))) begin
      key_bit = key_r[addr];
    end else begin
      key_bit = 1'b0;
    end
  end

endmodule

// File: tb/tb_secret_key_loader.sv
// Directed bench for secret_key_loader: table of read-port vectors after a
// known load, plus hand-written load, stall, restart and zeroize sequences.
module tb_secret_key_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       zeroize = 1'b0;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       busy;
  logic       key_valid;
  logic [8:0] addr = 9'd0;
  logic       key_bit;

  int n_vec  = 0;
  int n_fail = 0;

  logic [7:0] beats [56];
  logic       exp_key [445];
  logic       exp_valid;

  typedef struct {
    logic [8:0] a;
    logic       exp;
  } vec_t;
  vec_t tbl [16];

  secret_key_loader dut (
    .clk(clk), .rst(rst), .zeroize(zeroize), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .busy(busy), .key_valid(key_valid), .addr(addr), .key_bit(key_bit)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_model();
    for (int i = 0; i < 445; i++) exp_key[i] = beats[i / 8][i % 8];
  endtask

  // Sweep every address 0..511 and count bits that differ from the model.
  task automatic check_all(input string name);
    int bad;
    logic e;
    bad = 0;
    for (int a = 0; a < 512; a++) begin
      addr = 9'(a);
      #1;
      e = (exp_valid && a < 445) ? exp_key[a] : 1'b0;
      if (key_bit !== e) bad++;
    end
    check(name, 32'(bad), 32'd0);
  endtask

  task automatic begin_load(input logic stray_valid, input logic [7:0] stray);
    start = 1'b1;
    in_valid = stray_valid;
    in_data = stray;
    tick();
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  // Stream beats[] with optional random gaps; checks key_valid timing.
  task automatic stream(input int max_gap, input string name);
    int gap;
    logic rdy_ok;
    rdy_ok = 1'b1;
    for (int k = 0; k < 56; k++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        if (in_ready !== 1'b1) rdy_ok = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_data = beats[k];
      if (in_ready !== 1'b1) rdy_ok = 1'b0;
      if (k == 55) check({name, "_kv_before_last"}, 32'(key_valid), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    check({name, "_ready_held"}, 32'(rdy_ok), 32'd1);
    check({name, "_kv_after_last"}, 32'(key_valid), 32'd1);
    check({name, "_busy_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    tbl[0]  = '{9'd0,   1'b1};
    tbl[1]  = '{9'd8,   1'b0};
    tbl[2]  = '{9'd9,   1'b1};
    tbl[3]  = '{9'd16,  1'b1};
    tbl[4]  = '{9'd17,  1'b1};
    tbl[5]  = '{9'd18,  1'b0};
    tbl[6]  = '{9'd26,  1'b1};
    tbl[7]  = '{9'd98,  1'b1};
    tbl[8]  = '{9'd100, 1'b0};
    tbl[9]  = '{9'd440, 1'b0};
    tbl[10] = '{9'd442, 1'b0};
    tbl[11] = '{9'd443, 1'b1};
    tbl[12] = '{9'd444, 1'b1};
    tbl[13] = '{9'd445, 1'b0};
    tbl[14] = '{9'd447, 1'b0};
    tbl[15] = '{9'd511, 1'b0};

    // Reset then idle
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_key_valid", 32'(key_valid), 32'd0);
    addr = 9'd0;   #1; check("rst_bit0", 32'(key_bit), 32'd0);
    addr = 9'd444; #1; check("rst_bit444", 32'(key_bit), 32'd0);

    // in_valid in IDLE is ignored
    in_valid = 1'b1; in_data = 8'hFF;
    tick(); tick();
    in_valid = 1'b0;
    check("idle_valid_busy", 32'(busy), 32'd0);
    check("idle_valid_kv", 32'(key_valid), 32'd0);

    // Full back-to-back load of 0x01..0x38
    for (int k = 0; k < 56; k++) beats[k] = 8'(k + 1);
    build_model();
    begin_load(1'b0, 8'h00);
    check("load_busy", 32'(busy), 32'd1);
    check("load_in_ready", 32'(in_ready), 32'd1);
    stream(0, "b2b");
    foreach (tbl[i]) begin
      addr = tbl[i].a;
      #1;
      check($sformatf("tbl_addr%0d", tbl[i].a), 32'(key_bit), 32'(tbl[i].exp));
    end
    exp_valid = 1'b1;
    check_all("b2b_all");

    // in_valid in READY changes nothing
    in_valid = 1'b1; in_data = 8'h00;
    tick(); tick(); tick();
    in_valid = 1'b0;
    check("ready_valid_kv", 32'(key_valid), 32'd1);
    check_all("ready_valid_all");

    // Rekey from READY with a truncated final beat
    for (int k = 0; k < 55; k++) beats[k] = 8'hFF;
    beats[55] = 8'hE0;
    build_model();
    begin_load(1'b0, 8'h00);
    check("rekey_kv_drop", 32'(key_valid), 32'd0);
    addr = 9'd0; #1;
    check("rekey_bit_gated", 32'(key_bit), 32'd0);
    stream(0, "trunc");
    check_all("trunc_all");
    addr = 9'd439; #1; check("trunc_439", 32'(key_bit), 32'd1);
    addr = 9'd440; #1; check("trunc_440", 32'(key_bit), 32'd0);
    addr = 9'd444; #1; check("trunc_444", 32'(key_bit), 32'd0);

    // Stalled stream must equal the gap-free key
    for (int k = 0; k < 56; k++) beats[k] = 8'(k + 1);
    build_model();
    begin_load(1'b0, 8'h00);
    stream(3, "stall");
    check_all("stall_all");

    // Restart after 20 beats; the stray beat on the restart edge is dropped
    begin_load(1'b0, 8'h00);
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1; in_data = 8'hA5;
      tick();
    end
    begin_load(1'b1, 8'hFF);
    check("restart_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 56; k++) beats[k] = 8'(k) ^ 8'h3C;
    build_model();
    stream(1, "restart");
    check_all("restart_all");

    // zeroize and start together in READY
    zeroize = 1'b1; start = 1'b1;
    tick();
    zeroize = 1'b0; start = 1'b0;
    check("zero_busy", 32'(busy), 32'd0);
    check("zero_in_ready", 32'(in_ready), 32'd0);
    check("zero_kv", 32'(key_valid), 32'd0);
    exp_valid = 1'b0;
    check_all("zero_all");
    tick();
    check("zero_stays_idle", 32'(busy), 32'd0);

    // zeroize during LOAD overrides a transfer
    begin_load(1'b0, 8'h00);
    in_valid = 1'b1; in_data = 8'h11;
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0; in_valid = 1'b0;
    check("zero_load_busy", 32'(busy), 32'd0);

    // Reset mid-load clears everything, then a fresh load works
    begin_load(1'b0, 8'h00);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = 8'h77;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_kv", 32'(key_valid), 32'd0);
    for (int k = 0; k < 56; k++) beats[k] = 8'(8'hC3 + k);
    build_model();
    begin_load(1'b0, 8'h00);
    stream(0, "post_rst");
    exp_valid = 1'b1;
    check_all("post_rst_all");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1);
  end

endmodule
